// File: rtl/uart_boot_ctrl.sv
// UART boot sequencer: ASCII-hex program load into instruction memory, CPU start, halt report.
// Optional byte echo is enabled by defining BOOTCTRL_ECHO_EN.
module uart_boot_ctrl #(
  parameter int          ADDR_W    = 4,
  parameter logic [7:0]  HALT_CHAR = 8'h48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              rx_clr,
  input  logic              tx_busy,
  output logic              tx_wr,
  output logic [7:0]        tx_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              run_req,
  output logic              cpu_run,
  input  logic              cpu_halt,
  output logic [ADDR_W:0]   word_cnt,
  output logic              ovf,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {LOAD = 2'd0, RUN = 2'd1, HALTED = 2'd2} state_t;

  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  state_t      state, next_state;
  logic [2:0]  nib_cnt;
  logic [31:0] word;
  logic        halt_pend;
  logic        accept, halt_fire;
  logic        is_x, is_r;
  logic [4:0]  hex;
  logic        do_clear, do_digit, do_start, set_halt;

  // Returns {valid, nibble}; letters map via low nibble + 9 for both cases.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    if (c inside {[8'h30:8'h39]}) begin
      return {1'b1, c[3:0]};
    end else if (c inside {[8'h41:8'h46], [8'h61:8'h66]}) begin
      return {1'b1, c[3:0] + 4'd9};
    end else begin
      return 5'd0;
    end
  endfunction

  // A byte is taken only once: the cycle rx_clr is high the uart still shows rx_rdy.
`ifdef BOOTCTRL_ECHO_EN
  assign accept = rx_rdy && !rx_clr && !tx_busy && !tx_wr && !halt_pend;
`else
  assign accept = rx_rdy && !rx_clr;
`endif

  assign halt_fire = halt_pend && !tx_busy && !tx_wr;
  assign hex       = hex_decode(rx_data);
  assign is_x      = (rx_data == 8'h58);
  assign is_r      = (rx_data == 8'h52);
  assign state_o   = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    do_clear   = 1'b0;
    do_digit   = 1'b0;
    do_start   = 1'b0;
    set_halt   = 1'b0;
    case (state)
      LOAD: begin
        if (run_req || (accept && is_r)) begin
          next_state = RUN;
          do_start   = 1'b1;
        end else if (accept && is_x) begin
          do_clear = 1'b1;
        end else if (accept && hex[4]) begin
          do_digit = 1'b1;
        end else begin
          do_clear = 1'b0;
        end
      end
      RUN: begin
        if (accept && is_x) begin
          next_state = LOAD;
          do_clear   = 1'b1;
        end else if (cpu_halt) begin
          next_state = HALTED;
          set_halt   = 1'b1;
        end else begin
          next_state = RUN;
        end
      end
      HALTED: begin
        if (accept && is_x) begin
          next_state = LOAD;
          do_clear   = 1'b1;
        end else if (accept && is_r) begin
          next_state = RUN;
        end else begin
          next_state = HALTED;
        end
      end
      default: next_state = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_clr     <= 1'b0;
      tx_wr      <= 1'b0;
      tx_data    <= 8'd0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      cpu_run    <= 1'b0;
      word_cnt   <= '0;
      ovf        <= 1'b0;
      nib_cnt    <= 3'd0;
      word       <= 32'd0;
      halt_pend  <= 1'b0;
    end else begin
      rx_clr  <= accept;
      imem_we <= 1'b0;
      tx_wr   <= 1'b0;
      cpu_run <= (next_state == RUN);

      // HALT_CHAR outranks echo; echo acceptance is blocked while it is pending.
      if (halt_fire) begin
        tx_wr     <= 1'b1;
        tx_data   <= HALT_CHAR;
        halt_pend <= 1'b0;
      end
`ifdef BOOTCTRL_ECHO_EN
      else if (accept) begin
        tx_wr   <= 1'b1;
        tx_data <= rx_data;
      end
`endif

      if (set_halt) begin
        halt_pend <= 1'b1;
      end else if (state == HALTED && next_state != HALTED) begin
        halt_pend <= 1'b0;
      end

      if (do_clear) begin
        word_cnt <= '0;
        nib_cnt  <= 3'd0;
        word     <= 32'd0;
        ovf      <= 1'b0;
      end else if (do_start) begin
        nib_cnt <= 3'd0;
      end else if (do_digit) begin
        word <= {word[27:0], hex[3:0]};
        if (nib_cnt == 3'd7) begin
          nib_cnt <= 3'd0;
          if (word_cnt == FULL) begin
            ovf <= 1'b1;
          end else begin
            imem_we    <= 1'b1;
            imem_addr  <= word_cnt[ADDR_W-1:0];
            imem_wdata <= {word[27:0], hex[3:0]};
            word_cnt   <= word_cnt + {{ADDR_W{1'b0}}, 1'b1};
          end
        end else begin
          nib_cnt <= nib_cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: doc/uart_boot_ctrl.md
Name: uart_boot_ctrl

Overview:
Sequences the UART-to-CPU program-load flow. It consumes received bytes, decodes ASCII hex into 32-bit instruction words and writes them into instruction memory. On a run command it starts the pipelined CPU, then watches for halt and reports it over UART TX. It sits between the uart instance (rdy/dout/rdy_clr, din/wr_en/tx_busy) and the CPU's instruction-memory write port and start input.

Parameters:
ADDR_W, 4, instruction-memory word-address width; DEPTH = 2**ADDR_W words
HALT_CHAR, 8'h48, byte transmitted once when the CPU halts ('H')

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rx_rdy  in  1  uart has a received byte
rx_data  in  8  received byte
rx_clr  out  1  one-cycle pulse; consumes the current rx byte
tx_busy  in  1  uart transmitter busy
tx_wr  out  1  one-cycle pulse; load tx_data into uart
tx_data  out  8  byte to transmit
imem_we  out  1  instruction-memory write strobe (one cycle)
imem_addr  out  ADDR_W  word address of the write
imem_wdata  out  32  instruction word
run_req  in  1  external start pulse (e.g. button), LOAD state only
cpu_run  out  1  CPU start/enable; level
cpu_halt  in  1  CPU halt flag (ebreak retired)
word_cnt  out  ADDR_W+1  words loaded since last clear (0..DEPTH)
ovf  out  1  sticky: a word was completed with memory full
state_o  out  2  LOAD=0, RUN=1, HALTED=2

Behaviour:
- All logic clocked on clk. rst is synchronous, active-high, and wins over every other event, including mid-run and mid-word.
- Reset values: state=LOAD; all outputs 0; nibble counter 0; word shift register 0.
- Byte acceptance: a byte is accepted in any state when rx_rdy=1 and tx_busy=0. On the acceptance cycle, rx_clr=1 the next cycle (registered). When tx_busy=1, the byte is held, not consumed.
- LOAD, hex digit ('0'-'9', 'A'-'F', 'a'-'f'):
  - word <= {word[27:0], nibble}, MSB first; nib_cnt increments.
  - On the 8th digit: the next cycle drives imem_we=1, imem_addr=word_cnt[ADDR_W-1:0], imem_wdata=completed word. word_cnt increments and nib_cnt returns to 0.
  - If word_cnt==DEPTH: no write, ovf<=1, word dropped.
- LOAD, 'X' (8'h58): word_cnt, nib_cnt, word and ovf cleared. No imem write.
- LOAD, 'R' (8'h52), or run_req=1: partial word discarded (nib_cnt=0). Next cycle: state=RUN, cpu_run=1. If run_req and an 'R' byte coincide, a single transition occurs.
- LOAD, any other byte (CR, LF, space, etc.): consumed and ignored; partial word preserved.
- RUN: cpu_run held 1.
  - cpu_halt=1 -> next cycle state=HALTED, cpu_run=0.
  - Accepted 'X' -> cpu_run=0, state=LOAD, counters cleared (abort). Other bytes are consumed and ignored.
  - If cpu_halt and 'X' arrive in the same cycle, 'X' wins (-> LOAD, no HALT_CHAR sent).
- HALTED: tx_wr pulses once with tx_data=HALT_CHAR at the first cycle with tx_busy=0. 'X' -> LOAD with counters cleared. 'R' -> RUN (re-run same program; cpu_run low for at least one cycle between runs). Other bytes ignored.
- Echo (see Optional Feature) and HALT_CHAR never issue tx_wr in the same cycle; HALT_CHAR has priority and the echo waits.
- imem_we and tx_wr are never high for two consecutive cycles.

Optional Feature:
BOOTCTRL_ECHO_EN. When defined, every accepted byte is echoed: tx_wr=1 with tx_data=byte in the cycle after acceptance (acceptance already guarantees tx_busy=0). When undefined, byte acceptance ignores tx_busy, no echo is sent, and tx_wr is used only for HALT_CHAR.

Test Plan:
- Reset, send "00500093" then "R" -> imem_we once: addr 0, wdata 32'h00500093; word_cnt=1; cpu_run=1 one cycle after the 'R' acceptance.
- Send 17 complete 8-digit words with ADDR_W=4 -> 16 writes at addrs 0..15, word_cnt=16, 17th word not written, ovf=1; then 'X' -> word_cnt=0, ovf=0.
- Send "12\n34abCDEF" -> CR/LF ignored, imem_wdata=32'h1234ABCD after the 8th digit; the trailing "EF" stays partial (nib_cnt=2); 'R' discards it.
- In RUN, assert cpu_halt with tx_busy=1 for 5 cycles -> state=HALTED, cpu_run=0, tx_wr deferred until tx_busy=0, then exactly one pulse with tx_data=8'h48.
- ECHO_EN defined: hold tx_busy=1 while rx_rdy=1 -> no rx_clr. Release -> rx_clr and tx_wr with tx_data equal to rx_data. Undefined: same stimulus -> rx_clr immediately, no tx_wr.
- Assert rst mid-word (nib_cnt=5) and again during RUN -> all outputs 0, state=LOAD. Next 8 digits write address 0.
